// File: rtl/regfile_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_pkg: bank encodings, bank-state type, default sizes.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package regfile_pkg;

    localparam int W_DEF = 16;
    localparam int D_DEF = 8;

    localparam logic BANK_MAIN   = 1'b0;
    localparam logic BANK_SHADOW = 1'b1;

    typedef enum logic [0:0] {
        ST_MAIN   = BANK_MAIN,
        ST_SHADOW = BANK_SHADOW
    } bank_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_bank_ctl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_bank_ctl: main/shadow bank state machine with err pulse. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module regfile_bank_ctl
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic irq_enter,
    input  logic irq_ret,
    output logic bank,
    output logic err
);

    bank_state_t r_state;
    logic        r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_MAIN;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_MAIN: begin
                    if (irq_enter && !irq_ret)
                        r_state <= ST_SHADOW;
                    else if (irq_ret)
                        r_err <= 1'b1;
                end
                ST_SHADOW: begin
                    if (irq_ret && !irq_enter)
                        r_state <= ST_MAIN;
                    else if (irq_enter)
                        r_err <= 1'b1;
                end
                default: r_state <= ST_MAIN;
            endcase
        end
    end

    assign bank = r_state;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: rtl/regfile_banked.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_banked: D x W register file, main/shadow banks, 1W/2R.   |
// | Optional macro REGFILE_BYPASS_EN: write-through read forwarding. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module regfile_banked
    import regfile_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int D         = D_DEF,
    parameter int SHARED_LO = 1,
    parameter int ZERO_R0   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [$clog2(D)-1:0] wa,
    input  logic [W-1:0]         wd,
    input  logic [$clog2(D)-1:0] ra0,
    input  logic [$clog2(D)-1:0] ra1,
    output logic [W-1:0]         rd0,
    output logic [W-1:0]         rd1,
    input  logic                 irq_enter,
    input  logic                 irq_ret,
    output logic                 bank,
    output logic                 err
);

    localparam int AW = $clog2(D);

    logic [W-1:0] w_cur [D];

    regfile_bank_ctl u_bank_ctl (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_enter (irq_enter),
        .irq_ret   (irq_ret),
        .bank      (bank),
        .err       (err)
    );

    // w_cur[i] is register i as seen from the bank active this cycle.
    for (genvar i = 0; i < D; i++) begin : g_reg
        if (ZERO_R0 != 0 && i == 0) begin : g_zero
            assign w_cur[i] = '0;
        end else if (i < SHARED_LO) begin : g_shared
            logic [W-1:0] r_q;
            always_ff @(posedge clk) begin
                if (!rst_n)
                    r_q <= '0;
                else if (we && wa == AW'(i))
                    r_q <= wd;
            end
            assign w_cur[i] = r_q;
        end else begin : g_banked
            logic [W-1:0] r_q_main;
            logic [W-1:0] r_q_shadow;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_q_main   <= '0;
                    r_q_shadow <= '0;
                end else if (we && wa == AW'(i)) begin
                    if (bank == BANK_MAIN)
                        r_q_main <= wd;
                    else
                        r_q_shadow <= wd;
                end
            end
            assign w_cur[i] = (bank == BANK_SHADOW) ? r_q_shadow : r_q_main;
        end
    end

    always_comb begin
        rd0 = w_cur[ra0];
        rd1 = w_cur[ra1];
`ifdef REGFILE_BYPASS_EN
        // Both ports see the current bank, so address equality means same physical register.
        if (we && ra0 == wa && !(ZERO_R0 != 0 && ra0 == '0))
            rd0 = wd;
        if (we && ra1 == wa && !(ZERO_R0 != 0 && ra1 == '0))
            rd1 = wd;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_banked.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_regfile_banked: directed scoreboard bench for regfile_banked. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_regfile_banked;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [15:0] rd0;
    logic [15:0] rd1;
    logic        irq_enter;
    logic        irq_ret;
    logic        bank;
    logic        err;

    regfile_banked #(
        .W         (16),
        .D         (8),
        .SHARED_LO (2),
        .ZERO_R0   (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .ra0       (ra0),
        .ra1       (ra1),
        .rd0       (rd0),
        .rd1       (rd1),
        .irq_enter (irq_enter),
        .irq_ret   (irq_ret),
        .bank      (bank),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sig;
        logic [15:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    logic [15:0] m_main   [8];
    logic [15:0] m_shadow [8];
    logic        m_bank;
    logic        m_err;

    function automatic logic [15:0] model_read(input logic [2:0] a);
        if (a == 3'd0) return 16'h0000;
        if (a < 3'd2)  return m_main[a];
        return m_bank ? m_shadow[a] : m_main[a];
    endfunction

    function automatic logic [15:0] model_port(input logic [2:0] a, input logic w,
                                               input logic [2:0] w_a, input logic [15:0] w_d);
        logic [15:0] v;
        v = model_read(a);
`ifdef REGFILE_BYPASS_EN
        if (w && a == w_a && a != 3'd0) v = w_d;
`else
        if (w && w_a == 3'd7 && a == 3'd7 && 1'b0) v = w_d;
`endif
        return v;
    endfunction

    task automatic model_edge(input logic rn, input logic w, input logic [2:0] w_a,
                              input logic [15:0] w_d, input logic ie, input logic ir);
        logic illegal;
        if (!rn) begin
            for (int k = 0; k < 8; k++) begin
                m_main[k]   = 16'h0000;
                m_shadow[k] = 16'h0000;
            end
            m_bank = 1'b0;
            m_err  = 1'b0;
        end else begin
            if (w && w_a != 3'd0) begin
                if (w_a < 3'd2 || !m_bank) m_main[w_a] = w_d;
                else                       m_shadow[w_a] = w_d;
            end
            illegal = (ie && ir) || (ie && m_bank) || (ir && !m_bank);
            m_err   = illegal;
            if (!illegal && ie) m_bank = 1'b1;
            if (!illegal && ir) m_bank = 1'b0;
        end
    endtask

    task automatic check_outputs();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sig)
                0:       obs = rd0;
                1:       obs = rd1;
                2:       obs = {15'b0, bank};
                default: obs = {15'b0, err};
            endcase
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s/sig%0d: observed %h expected %h", e.tag, e.sig, obs, e.exp);
            end
        end
    endtask

    // One clock cycle: drive, check combinational/registered outputs, advance model at the edge.
    task automatic cycle(input string tag, input logic rn, input logic w, input logic [2:0] w_a,
                         input logic [15:0] w_d, input logic [2:0] a0, input logic [2:0] a1,
                         input logic ie, input logic ir);
        rst_n = rn; we = w; wa = w_a; wd = w_d; ra0 = a0; ra1 = a1;
        irq_enter = ie; irq_ret = ir;
        #2;
        sb.push_back('{tag, 0, model_port(a0, w, w_a, w_d)});
        sb.push_back('{tag, 1, model_port(a1, w, w_a, w_d)});
        sb.push_back('{tag, 2, {15'b0, m_bank}});
        sb.push_back('{tag, 3, {15'b0, m_err}});
        check_outputs();
        @(posedge clk);
        model_edge(rn, w, w_a, w_d, ie, ir);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra0 = '0; ra1 = '0;
        irq_enter = 1'b0; irq_ret = 1'b0;
        repeat (2) @(posedge clk);
        model_edge(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        #1;

        // reset state and simple write/read
        cycle("rst_state", 1, 0, 3'd0, 16'h0000, 3'd3, 3'd7, 0, 0);
        cycle("wr_r3",     1, 1, 3'd3, 16'hA5A5, 3'd3, 3'd4, 0, 0);
        cycle("rd_r3",     1, 0, 3'd0, 16'h0000, 3'd3, 3'd3, 0, 0);

        // bank isolation of r3
        cycle("wr_r3_main", 1, 1, 3'd3, 16'h1111, 3'd3, 3'd0, 0, 0);
        cycle("enter1",     1, 0, 3'd0, 16'h0000, 3'd3, 3'd3, 1, 0);
        cycle("wr_r3_shad", 1, 1, 3'd3, 16'h2222, 3'd3, 3'd1, 0, 0);
        cycle("ret1",       1, 0, 3'd0, 16'h0000, 3'd3, 3'd3, 0, 1);
        cycle("rd_r3_main", 1, 0, 3'd0, 16'h0000, 3'd3, 3'd3, 0, 0);
        cycle("enter2",     1, 0, 3'd0, 16'h0000, 3'd3, 3'd3, 1, 0);
        cycle("rd_r3_shad", 1, 0, 3'd0, 16'h0000, 3'd3, 3'd3, 0, 0);
        cycle("ret2",       1, 0, 3'd0, 16'h0000, 3'd3, 3'd3, 0, 1);

        // shared r1 vs banked r2 boundary
        cycle("wr_r1",      1, 1, 3'd1, 16'h00FF, 3'd1, 3'd2, 0, 0);
        cycle("enter3",     1, 0, 3'd0, 16'h0000, 3'd1, 3'd2, 1, 0);
        cycle("wr_r2_shad", 1, 1, 3'd2, 16'hBEEF, 3'd1, 3'd2, 0, 0);
        cycle("rd_r1_r2_s", 1, 0, 3'd0, 16'h0000, 3'd1, 3'd2, 0, 0);
        cycle("wr_r1_shad", 1, 1, 3'd1, 16'h0F0F, 3'd1, 3'd2, 0, 1);
        cycle("rd_r1_r2_m", 1, 0, 3'd0, 16'h0000, 3'd1, 3'd2, 0, 0);

        // zero register in both banks, including same-cycle reads
        cycle("wr_r0_main", 1, 1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 0, 0);
        cycle("rd_r0_main", 1, 0, 3'd0, 16'h0000, 3'd0, 3'd0, 1, 0);
        cycle("wr_r0_shad", 1, 1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 0, 0);
        cycle("rd_r0_shad", 1, 0, 3'd0, 16'h0000, 3'd0, 3'd0, 0, 0);

        // illegal requests: nested enter, both at once, return in MAIN
        cycle("nested",     1, 0, 3'd0, 16'h0000, 3'd3, 3'd2, 1, 0);
        cycle("nested_err", 1, 0, 3'd0, 16'h0000, 3'd3, 3'd2, 0, 0);
        cycle("err_clear",  1, 0, 3'd0, 16'h0000, 3'd3, 3'd2, 0, 1);
        cycle("both_main",  1, 0, 3'd0, 16'h0000, 3'd3, 3'd2, 1, 1);
        cycle("both_err",   1, 0, 3'd0, 16'h0000, 3'd3, 3'd2, 0, 1);
        cycle("ret_err",    1, 0, 3'd0, 16'h0000, 3'd3, 3'd2, 0, 0);
        cycle("quiet",      1, 0, 3'd0, 16'h0000, 3'd3, 3'd2, 0, 0);

        // write at the same edge as a switch lands in the old bank
        cycle("wr_r5_enter", 1, 1, 3'd5, 16'h1234, 3'd3, 3'd5, 1, 0);
        cycle("rd_r5_shad",  1, 0, 3'd0, 16'h0000, 3'd5, 3'd5, 0, 1);
        cycle("rd_r5_main",  1, 0, 3'd0, 16'h0000, 3'd5, 3'd3, 1, 0);
        cycle("wr_r6_shad",  1, 1, 3'd6, 16'h6666, 3'd6, 3'd5, 0, 0);

        // reset in SHADOW with a concurrent write and switch request
        cycle("rst_in_shad", 0, 1, 3'd4, 16'h7777, 3'd5, 3'd6, 0, 1);
        cycle("post_rst_a",  1, 0, 3'd0, 16'h0000, 3'd5, 3'd4, 0, 0);
        cycle("post_rst_b",  1, 0, 3'd0, 16'h0000, 3'd3, 3'd1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_banked.md
Name: regfile_banked

Overview:
- Parametrised successor to the single loadable register: a bank of D registers, each W bits wide.
- One synchronous write port and two combinational read ports.
- A main/shadow bank pair switches in one cycle on interrupt entry and return.
- Used by the interrupt-capable CPU datapath, so the handler gets private working registers without software save/restore.

Parameters:
- W, 16: data width of every register and data bus.
- D, 8: registers per bank, D >= 2, power of two. Localparam AW = $clog2(D).
- SHARED_LO, 1: registers with index < SHARED_LO are a single physical copy shared by both banks. 0 <= SHARED_LO <= D.
- ZERO_R0, 1: if 1, register 0 always reads 0 and writes to it are discarded.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- rst_n, in, 1: synchronous active-low reset, sampled on the rising edge of clk.
- we, in, 1: write enable.
- wa, in, AW: write address.
- wd, in, W: write data.
- ra0, in, AW: read address, port 0.
- ra1, in, AW: read address, port 1.
- rd0, out, W: read data, port 0; combinational.
- rd1, out, W: read data, port 1; combinational.
- irq_enter, in, 1: one-cycle request to switch to the shadow bank.
- irq_ret, in, 1: one-cycle request to switch back to the main bank.
- bank, out, 1: active bank; 0 = main, 1 = shadow; registered.
- err, out, 1: registered one-cycle pulse flagging an illegal bank request.

Behaviour:
- Reset (rst_n == 0 at a rising edge of clk): all registers in both banks are cleared to 0, bank = 0 and err = 0. Reset has priority over all other inputs. A write or switch presented in the same cycle is discarded.
- Read:
  - rd0 and rd1 show the register at ra0 and ra1 in the current bank, with zero latency (combinational).
  - Index < SHARED_LO reads the shared copy.
  - Index 0 with ZERO_R0 == 1 reads 0.
- Write:
  - At the rising edge with we == 1, wd is stored at wa.
  - The target bank is the value of bank before the edge, even when a switch happens at the same edge.
  - The new value is visible on rd0/rd1 from the next cycle.
- Bank state machine, two states, MAIN (bank = 0) and SHADOW (bank = 1):
  - MAIN with irq_enter = 1 and irq_ret = 0: go to SHADOW.
  - SHADOW with irq_ret = 1 and irq_enter = 0: go to MAIN.
  - irq_enter in SHADOW (nested interrupt), irq_ret in MAIN, or both requests high together: no state change, err = 1 for the next cycle.
  - Otherwise err = 0.
- Banked registers keep their contents across bank switches; switching never clears them.
- Out-of-range or unused indices do not exist, because D is a power of two.
- Reset during SHADOW returns to MAIN and clears both banks.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when we == 1 and a read address equals wa, that read port returns wd in the same cycle (write-through forwarding).
  - Forwarding applies only when the read and write resolve to the same physical register in the current bank.
  - It never forwards to register 0 when ZERO_R0 == 1.
- Not defined: reads return the stored value before the edge, and new data appears the next cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - the bank encodings BANK_MAIN = 1'b0 and BANK_SHADOW = 1'b1;
  - the two-state bank-state typedef;
  - the default W and D constants.
- One natural sub-module, regfile_bank_ctl: the bank state machine plus err generation. Inputs are clk, rst_n, irq_enter and irq_ret; outputs are bank and err.
- The storage array and read muxing stay in regfile_banked.

Test Plan:
1. Reset, then write 16'hA5A5 to r3 in MAIN and read r3 on ra0 the next cycle -> rd0 = 16'hA5A5, bank = 0, err = 0.
2. Write r3 = 16'h1111 in MAIN, pulse irq_enter, write r3 = 16'h2222, pulse irq_ret -> rd0 at r3 = 16'h1111. Pulse irq_enter again -> rd0 = 16'h2222.
3. SHARED_LO = 2: write r1 = 16'h00FF in MAIN, then irq_enter -> r1 still reads 16'h00FF in SHADOW.
4. Write r0 = 16'hFFFF with ZERO_R0 = 1 -> rd0 and rd1 at r0 read 0 in both banks. Repeat with REGFILE_BYPASS_EN defined -> still 0 in the write cycle.
5. Illegal requests:
   - irq_enter while SHADOW -> err = 1 for exactly one cycle, bank stays 1.
   - irq_enter and irq_ret together in MAIN -> err = 1, bank stays 0.
   - irq_ret in MAIN -> err = 1, bank stays 0.
6. Write r5 = 16'h1234 while asserting irq_enter and ra1 = 5 -> the write lands in MAIN. With REGFILE_BYPASS_EN, rd1 = 16'h1234 in the same cycle; without it, the old value. Then assert rst_n = 0 in SHADOW -> next cycle bank = 0 and r5 reads 0.
